// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared state encoding, redirect-select codes and fetch constants
package pc_fetch_pkg;
  localparam int INSTR_BYTES = 4;
  typedef enum logic [2:0] {S_BOOT, S_FETCH, S_HOLD, S_DRAIN, S_ERR} state_t;
  typedef enum logic [2:0] {SEL_SEQ, SEL_BRANCH, SEL_JUMP, SEL_JR, SEL_FLUSH} sel_t;
endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// pc_fetch_sequencer_if: instruction-memory request/acknowledge port
interface pc_fetch_sequencer_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;
  modport master(output req, addr, input ack, rdata);
  modport slave(input req, addr, output ack, rdata);
endinterface

// File: rtl/pc_target_calc.sv
// pc_target_calc: priority mux for the next fetch PC (flush > jr > jump > branch > sequential)
module pc_target_calc
  import pc_fetch_pkg::*;
(
  input  logic [31:0] seq_pc,
  input  logic [31:0] pc_plus4,
  input  logic        take,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump_en,
  input  logic [25:0] jump_index,
  input  logic        jr_en,
  input  logic [31:0] jr_addr,
  input  logic        flush,
  input  logic [31:0] flush_addr,
  output logic [31:0] next_pc,
  output logic        misalign
);
  sel_t sel;
  // Redirects only count when decode consumes the instruction; flush always counts
  always_comb sel = flush ? SEL_FLUSH : !take ? SEL_SEQ : jr_en ? SEL_JR :
                    jump_en ? SEL_JUMP : branch_taken ? SEL_BRANCH : SEL_SEQ;
  // Target select; only jr and flush can produce an unaligned address
  always_comb begin
    case (sel)
      SEL_FLUSH:  next_pc = flush_addr;
      SEL_JR:     next_pc = jr_addr;
      SEL_JUMP:   next_pc = {pc_plus4[31:28], jump_index, 2'b00};
      SEL_BRANCH: next_pc = pc_plus4 + (branch_offset << 2);
      default:    next_pc = seq_pc;
    endcase
    misalign = |next_pc[1:0];
  end
endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: fetch-stage FSM owning the PC, imem requests and the decode instruction buffer
module pc_fetch_sequencer
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          MAX_WAIT     = 15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  pc_fetch_sequencer_if.master        imem,
  output logic [31:0]                 instr,
  output logic [31:0]                 instr_pc,
  output logic                        instr_valid,
  output logic [31:0]                 pc_plus4,
  input  logic                        stall,
  input  logic                        branch_taken,
  input  logic [31:0]                 branch_offset,
  input  logic                        jump_en,
  input  logic [25:0]                 jump_index,
  input  logic                        jr_en,
  input  logic [31:0]                 jr_addr,
  input  logic                        flush,
  input  logic [31:0]                 flush_addr,
  output logic                        fetch_err
);
  state_t      state, state_n;
  logic [31:0] fpc, fpc_n, addr, addr_n, instr_n, ipc_n, tgt;
  logic        req, req_n, valid_n, err_n, misalign, consume, timeout;
  logic [7:0]  cnt, cnt_n;
  assign imem.req  = req;
  assign imem.addr = addr;
  assign pc_plus4  = instr_pc + 32'(INSTR_BYTES);
  assign consume   = instr_valid && !stall;
  assign timeout   = req && !imem.ack && (cnt + 8'd1 == 8'(MAX_WAIT));
  pc_target_calc u_calc (
    .seq_pc(fpc), .pc_plus4(pc_plus4), .take(consume),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump_en(jump_en), .jump_index(jump_index),
    .jr_en(jr_en), .jr_addr(jr_addr),
    .flush(flush), .flush_addr(flush_addr),
    .next_pc(tgt), .misalign(misalign)
  );
  // Next-state logic; tgt already folds in flush/redirect priority for the current state
  always_comb begin
    state_n = state;
    fpc_n   = fpc;
    req_n   = req;
    addr_n  = addr;
    instr_n = instr;
    ipc_n   = instr_pc;
    valid_n = instr_valid;
    err_n   = fetch_err;
    cnt_n   = !req ? cnt : imem.ack ? 8'd0 : cnt + 8'd1;
    case (state)
      S_BOOT: begin
        state_n = S_FETCH;
        fpc_n   = tgt;
        req_n   = 1'b1;
        addr_n  = tgt;
      end
      S_FETCH:
        if (flush) begin
          fpc_n   = tgt;
          valid_n = 1'b0;
          state_n = imem.ack ? S_FETCH : S_DRAIN;
          addr_n  = imem.ack ? tgt : addr;
        end else if (imem.ack) begin
          instr_n = imem.rdata;
          ipc_n   = fpc;
          valid_n = 1'b1;
          fpc_n   = fpc + 32'(INSTR_BYTES);
          req_n   = 1'b0;
          state_n = S_HOLD;
        end
      S_HOLD:
        if (flush || consume) begin
          fpc_n   = tgt;
          valid_n = 1'b0;
          req_n   = 1'b1;
          addr_n  = tgt;
          state_n = S_FETCH;
        end
      S_DRAIN: begin
        fpc_n = tgt;
        if (imem.ack) begin
          addr_n  = tgt;
          state_n = S_FETCH;
        end
      end
      default: ;
    endcase
    if (state != S_ERR && (misalign || timeout)) begin
      state_n = S_ERR;
      req_n   = 1'b0;
      valid_n = 1'b0;
      err_n   = 1'b1;
    end
  end
  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= S_BOOT;
      fpc         <= RESET_VECTOR;
      req         <= 1'b0;
      addr        <= RESET_VECTOR;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      cnt         <= '0;
    end else begin
      state       <= state_n;
      fpc         <= fpc_n;
      req         <= req_n;
      addr        <= addr_n;
      instr       <= instr_n;
      instr_pc    <= ipc_n;
      instr_valid <= valid_n;
      fetch_err   <= err_n;
      cnt         <= cnt_n;
    end
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: directed vector table plus hand sequences for the fetch sequencer
module tb_pc_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr, instr_pc, pc_plus4, branch_offset, jr_addr, flush_addr;
  logic        instr_valid, stall, branch_taken, jump_en, jr_en, flush, fetch_err;
  logic [25:0] jump_index;
  int          total = 0;
  int          bad = 0;
  typedef struct {
    logic [31:0] base;
    logic        br;
    logic [31:0] off;
    logic        j;
    logic [25:0] idx;
    logic        jr;
    logic [31:0] jra;
    logic [31:0] exp_addr;
    logic        exp_err;
  } vec_t;
  vec_t vecs[9];
  pc_fetch_sequencer_if imem();
  pc_fetch_sequencer #(.RESET_VECTOR(32'h0), .MAX_WAIT(15)) dut (
    .clk(clk), .rst_n(rst_n), .imem(imem),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .pc_plus4(pc_plus4),
    .stall(stall), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump_en(jump_en), .jump_index(jump_index), .jr_en(jr_en), .jr_addr(jr_addr),
    .flush(flush), .flush_addr(flush_addr), .fetch_err(fetch_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    stall = 0; branch_taken = 0; branch_offset = 0; jump_en = 0; jump_index = 0;
    jr_en = 0; jr_addr = 0; flush = 0; flush_addr = 0; imem.ack = 0; imem.rdata = 0;
  endtask
  task automatic do_reset();
    clr();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask
  task automatic ack_once(input logic [31:0] d);
    imem.ack = 1;
    imem.rdata = d;
    step();
    imem.ack = 0;
  endtask
  task automatic run_row(input vec_t v, input int i);
    do_reset();
    step();
    ack_once(32'h0);
    stall = 1; flush = 1; flush_addr = v.base;
    step();
    flush = 0; stall = 0;
    chk($sformatf("row%0d flush req", i), 32'(imem.req), 32'd1);
    chk($sformatf("row%0d flush addr", i), imem.addr, v.base);
    ack_once(v.base ^ 32'h5A5A_0000);
    chk($sformatf("row%0d instr_pc", i), instr_pc, v.base);
    chk($sformatf("row%0d pc_plus4", i), pc_plus4, v.base + 32'd4);
    chk($sformatf("row%0d instr", i), instr, v.base ^ 32'h5A5A_0000);
    branch_taken = v.br; branch_offset = v.off; jump_en = v.j; jump_index = v.idx;
    jr_en = v.jr; jr_addr = v.jra;
    step();
    clr();
    chk($sformatf("row%0d err", i), 32'(fetch_err), 32'(v.exp_err));
    chk($sformatf("row%0d req", i), 32'(imem.req), 32'(!v.exp_err));
    chk($sformatf("row%0d valid", i), 32'(instr_valid), 32'd0);
    if (!v.exp_err) chk($sformatf("row%0d addr", i), imem.addr, v.exp_addr);
  endtask
  initial begin
    vecs[0] = '{32'h0000_0010, 1, 32'hFFFF_FFFE, 0, 26'h0, 0, 32'h0, 32'h0000_000C, 0};
    vecs[1] = '{32'h1000_0040, 0, 32'h0, 1, 26'h100, 0, 32'h0, 32'h1000_0400, 0};
    vecs[2] = '{32'h0000_0020, 1, 32'h5, 0, 26'h0, 1, 32'h0000_3000, 32'h0000_3000, 0};
    vecs[3] = '{32'h0000_0040, 0, 32'h0, 1, 26'h7, 1, 32'h0000_0500, 32'h0000_0500, 0};
    vecs[4] = '{32'h0000_0040, 1, 32'h1, 1, 26'h10, 0, 32'h0, 32'h0000_0040, 0};
    vecs[5] = '{32'h0000_0100, 0, 32'h0, 0, 26'h0, 0, 32'h0, 32'h0000_0104, 0};
    vecs[6] = '{32'hFFFF_FFFC, 0, 32'h0, 0, 26'h0, 0, 32'h0, 32'h0000_0000, 0};
    vecs[7] = '{32'hFFFF_FFF0, 1, 32'h8, 0, 26'h0, 0, 32'h0, 32'h0000_0014, 0};
    vecs[8] = '{32'h0000_0010, 0, 32'h0, 0, 26'h0, 1, 32'h0000_0042, 32'h0, 1};
    clr();
    step();
    chk("rst req", 32'(imem.req), 32'd0);
    chk("rst addr", imem.addr, 32'h0);
    chk("rst valid", 32'(instr_valid), 32'd0);
    chk("rst instr", instr, 32'h0);
    chk("rst instr_pc", instr_pc, 32'h0);
    chk("rst err", 32'(fetch_err), 32'd0);
    // boot cycle, then sequential fetch with stall
    rst_n = 1;
    chk("boot req", 32'(imem.req), 32'd0);
    step();
    chk("fetch req", 32'(imem.req), 32'd1);
    chk("fetch addr", imem.addr, 32'h0);
    chk("pre-ack valid", 32'(instr_valid), 32'd0);
    stall = 1;
    ack_once(32'h2408_000A);
    chk("seq valid", 32'(instr_valid), 32'd1);
    chk("seq instr", instr, 32'h2408_000A);
    chk("seq instr_pc", instr_pc, 32'h0);
    chk("seq pc_plus4", pc_plus4, 32'h4);
    chk("hold req", 32'(imem.req), 32'd0);
    jr_en = 1; jr_addr = 32'h200;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("stall%0d instr", k), instr, 32'h2408_000A);
      chk($sformatf("stall%0d valid", k), 32'(instr_valid), 32'd1);
      chk($sformatf("stall%0d req", k), 32'(imem.req), 32'd0);
    end
    jr_en = 0; stall = 0;
    step();
    chk("consume valid", 32'(instr_valid), 32'd0);
    chk("next req", 32'(imem.req), 32'd1);
    chk("next addr", imem.addr, 32'h4);
    // flush in FETCH without ack drains the outstanding request
    flush = 1; flush_addr = 32'h8000_0180;
    step();
    flush = 0;
    chk("drain req", 32'(imem.req), 32'd1);
    chk("drain addr", imem.addr, 32'h4);
    step();
    step();
    chk("drain hold addr", imem.addr, 32'h4);
    ack_once(32'hDEAD_BEEF);
    chk("drain discard", 32'(instr_valid), 32'd0);
    chk("post-drain req", 32'(imem.req), 32'd1);
    chk("post-drain addr", imem.addr, 32'h8000_0180);
    ack_once(32'h1234_5678);
    chk("flush instr_pc", instr_pc, 32'h8000_0180);
    chk("flush instr", instr, 32'h1234_5678);
    // flush beats a jr redirect on the same consume
    jr_en = 1; jr_addr = 32'h300; flush = 1; flush_addr = 32'h600;
    step();
    clr();
    chk("flush-vs-jr addr", imem.addr, 32'h600);
    // flush in FETCH coinciding with ack: data dropped, refetch at flush target
    flush = 1; flush_addr = 32'h400;
    ack_once(32'hAAAA_5555);
    flush = 0;
    chk("flush+ack valid", 32'(instr_valid), 32'd0);
    chk("flush+ack req", 32'(imem.req), 32'd1);
    chk("flush+ack addr", imem.addr, 32'h400);
    // misaligned flush target
    flush = 1; flush_addr = 32'h401;
    step();
    flush = 0;
    chk("flush misalign err", 32'(fetch_err), 32'd1);
    chk("flush misalign req", 32'(imem.req), 32'd0);
    // timeout: 15 unacked request cycles
    do_reset();
    step();
    repeat (14) step();
    chk("pre-timeout err", 32'(fetch_err), 32'd0);
    chk("pre-timeout req", 32'(imem.req), 32'd1);
    step();
    chk("timeout err", 32'(fetch_err), 32'd1);
    chk("timeout req", 32'(imem.req), 32'd0);
    imem.ack = 1; flush = 1; flush_addr = 32'h40;
    repeat (3) step();
    clr();
    chk("err sticky", 32'(fetch_err), 32'd1);
    chk("err req", 32'(imem.req), 32'd0);
    chk("err valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 9; i++) run_row(vecs[i], i);
    do_reset();
    chk("reset clears err", 32'(fetch_err), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
